// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller.
// CPU side: single-byte load/store, one at a time. Memory side: block request/ready handshake.
module dm_cache_ctrl #(
    parameter int BLOCK_BYTES = 4,
    parameter int NUM_LINES   = 16,
    parameter int ADDR_W      = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cpu_req_valid,
    input  logic                                cpu_write,
    input  logic [ADDR_W-1:0]                   cpu_addr,
    input  logic [7:0]                          cpu_wdata,
    output logic                                cpu_ready,
    output logic                                cpu_resp_valid,
    output logic [7:0]                          cpu_rdata,
    output logic                                mem_req_valid,
    output logic                                mem_write,
    output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0] mem_addr,
    output logic [BLOCK_BYTES*8-1:0]            mem_data_out,
    input  logic                                mem_ready,
    input  logic [BLOCK_BYTES*8-1:0]            mem_data_in
);

    localparam int OFF_W   = $clog2(BLOCK_BYTES);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int BADDR_W = ADDR_W - OFF_W;
    localparam int BLK_W   = BLOCK_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_LO, WB_HI, FILL_REQ, FILL_LO, FILL_HI
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [7:0]        req_wdata;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [BLK_W-1:0]     data_mem [NUM_LINES];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [BLK_W-1:0] line_data;
    logic [BLK_W-1:0] merged;
    logic [7:0]       hit_byte;
    logic             hit;
    logic             accept;

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign line_data = data_mem[req_idx];
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign hit_byte  = line_data[{req_off, 3'b000} +: 8];

    assign cpu_ready      = (state == IDLE) && !rst;
    assign accept         = cpu_req_valid && cpu_ready;
    assign cpu_resp_valid = (state == LOOKUP) && hit && !rst;
    assign cpu_rdata      = cpu_resp_valid ? (req_write ? req_wdata : hit_byte) : 8'h00;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        merged = line_data;
        merged[{req_off, 3'b000} +: 8] = req_wdata;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = LOOKUP;
            LOOKUP: begin
                if (hit)
                    state_next = IDLE;
                else if (valid[req_idx] && dirty[req_idx])
                    state_next = WB_REQ;
                else
                    state_next = FILL_REQ;
            end
            WB_REQ:   if (mem_ready)  state_next = WB_LO;
            WB_LO:    if (!mem_ready) state_next = WB_HI;
            WB_HI:    if (mem_ready)  state_next = FILL_REQ;
            FILL_REQ: if (mem_ready)  state_next = FILL_LO;
            FILL_LO:  if (!mem_ready) state_next = FILL_HI;
            FILL_HI:  if (mem_ready)  state_next = LOOKUP;
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            req_addr      <= '0;
            req_write     <= 1'b0;
            req_wdata     <= '0;
            mem_req_valid <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_data_out  <= '0;
        end else begin
            state         <= state_next;
            mem_req_valid <= 1'b0;
            if (accept) begin
                req_addr  <= cpu_addr;
                req_write <= cpu_write;
                req_wdata <= cpu_wdata;
            end
            case (state)
                LOOKUP: if (hit && req_write) dirty[req_idx] <= 1'b1;
                WB_REQ: begin
                    if (mem_ready) begin
                        mem_req_valid <= 1'b1;
                        mem_write     <= 1'b1;
                        mem_addr      <= {tag_mem[req_idx], req_idx};
                        mem_data_out  <= line_data;
                    end
                end
                WB_HI:  if (mem_ready) dirty[req_idx] <= 1'b0;
                FILL_REQ: begin
                    if (mem_ready) begin
                        mem_req_valid <= 1'b1;
                        mem_write     <= 1'b0;
                        mem_addr      <= req_addr[ADDR_W-1:OFF_W];
                    end
                end
                FILL_HI: begin
                    if (mem_ready) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag/data arrays are not reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == LOOKUP && hit && req_write)
                data_mem[req_idx] <= merged;
            else if (state == FILL_HI && mem_ready) begin
                data_mem[req_idx] <= mem_data_in;
                tag_mem[req_idx]  <= req_tag;
            end
        end
    end

    logic unused_baddr_w;
    assign unused_baddr_w = (BADDR_W == TAG_W + IDX_W);

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: vector table of loads/stores against a block memory model,
// plus hand sequences for a long memory stall and a reset during a fill.
module tb_dm_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic        cpu_resp_valid;
    logic [7:0]  cpu_rdata;
    logic        mem_req_valid;
    logic        mem_write;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_out;
    logic        mem_ready;
    logic [31:0] mem_data_in;

    dm_cache_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_write      (cpu_write),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ready      (cpu_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_rdata      (cpu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_data_out   (mem_data_out),
        .mem_ready      (mem_ready),
        .mem_data_in    (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_cnt = 0;
    int resp_cnt = 0;
    int wb_cnt = 0;
    int mem_delay = 3;
    int rise_cyc = 0;
    logic [29:0] last_maddr = '0;
    logic [29:0] last_wbaddr = '0;
    logic [31:0] last_wbdata = '0;

    logic [31:0] mem_model [logic [29:0]];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_req_valid) req_cnt <= req_cnt + 1;
    always @(negedge clk) if (cpu_resp_valid) resp_cnt <= resp_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Unwritten blocks: byte3 = a^F0, byte2 = a[29:22], byte1 = a^0F, byte0 = a (a = low address byte).
    function automatic logic [31:0] read_block(input logic [29:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[7:0] ^ 8'hF0, a[29:22], a[7:0] ^ 8'h0F, a[7:0]};
    endfunction

    // Block memory model: drops mem_ready on a request, raises it mem_delay cycles later.
    initial begin
        logic        wr;
        logic [29:0] a;
        mem_ready   = 1'b1;
        mem_data_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_valid) begin
                mem_ready  = 1'b0;
                wr         = mem_write;
                a          = mem_addr;
                last_maddr = a;
                if (wr) begin
                    mem_model[a] = mem_data_out;
                    last_wbaddr  = a;
                    last_wbdata  = mem_data_out;
                    wb_cnt++;
                end
                repeat (mem_delay) @(posedge clk);
                #1;
                if (!wr) mem_data_in = read_block(a);
                mem_ready = 1'b1;
                rise_cyc  = cyc;
            end
        end
    end

    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                              input logic hold, output logic [7:0] rd, output int lat,
                              output int resp_cyc, output int busy_err, output logic ok);
        int n;
        ok = 1'b0; rd = '0; lat = 0; resp_cyc = 0; busy_err = 0;
        @(negedge clk);
        n = 0;
        while (!cpu_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_ready) return;
        cpu_req_valid = 1'b1;
        cpu_write     = wr;
        cpu_addr      = addr;
        cpu_wdata     = wd;
        @(posedge clk);
        #1;
        if (hold) begin
            cpu_write = 1'b1;
            cpu_addr  = 32'h200;
            cpu_wdata = 8'h55;
        end else begin
            cpu_req_valid = 1'b0;
        end
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (cpu_resp_valid) begin
                rd = cpu_rdata; lat = i; resp_cyc = cyc; ok = 1'b1;
                break;
            end
            if (cpu_ready) busy_err++;
        end
        cpu_req_valid = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        int          exp_req;
        int          exp_wb;
        int          exp_lat;
        logic [29:0] exp_maddr;
        logic [29:0] exp_wbaddr;
        logic [31:0] exp_wbdata;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        logic [7:0] rd;
        int lat, rcyc, busy, r0, w0, q0, c0;
        logic ok, seen;

        // mem_delay = 3: clean miss answers in 7 cycles, dirty miss in 12, hit in 1.
        vecs[0]  = '{1'b0, 32'h0000_0100, 8'h00, 8'h44, 1, 0,  7, 30'h40,        30'h0,  32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0100, 8'h00, 8'h44, 0, 0,  1, 30'h0,         30'h0,  32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0101, 8'hAA, 8'hAA, 0, 0,  1, 30'h0,         30'h0,  32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0101, 8'h00, 8'hAA, 0, 0,  1, 30'h0,         30'h0,  32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0140, 8'h00, 8'h88, 2, 1, 12, 30'h50,        30'h40, 32'h1122AA44};
        vecs[5]  = '{1'b0, 32'h0000_0100, 8'h00, 8'h44, 1, 0,  7, 30'h40,        30'h0,  32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0101, 8'h00, 8'hAA, 0, 0,  1, 30'h0,         30'h0,  32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0140, 8'h00, 8'h88, 1, 0,  7, 30'h50,        30'h0,  32'h0};
        vecs[8]  = '{1'b1, 32'h0000_003F, 8'h5C, 8'h5C, 1, 0,  7, 30'h0F,        30'h0,  32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0040, 8'h00, 8'h10, 1, 0,  7, 30'h10,        30'h0,  32'h0};
        vecs[10] = '{1'b0, 32'h0000_003F, 8'h00, 8'h5C, 0, 0,  1, 30'h0,         30'h0,  32'h0};
        vecs[11] = '{1'b0, 32'h0000_003C, 8'h00, 8'h0F, 0, 0,  1, 30'h0,         30'h0,  32'h0};
        vecs[12] = '{1'b0, 32'h8000_003E, 8'h00, 8'h80, 2, 1, 12, 30'h2000000F, 30'h0F, 32'h5C00000F};
        vecs[13] = '{1'b0, 32'h0000_003F, 8'h00, 8'h5C, 1, 0,  7, 30'h0F,        30'h0,  32'h0};

        mem_model[30'h40] = 32'h11223344;
        mem_model[30'h50] = 32'h55667788;

        rst = 1'b1; cpu_req_valid = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ready",      cpu_ready,      1'b0);
        check("rst_cpu_resp_valid", cpu_resp_valid, 1'b0);
        check("rst_cpu_rdata",      cpu_rdata,      8'h00);
        check("rst_mem_req_valid",  mem_req_valid,  1'b0);
        check("rst_mem_write",      mem_write,      1'b0);
        check("rst_mem_addr",       mem_addr,       30'h0);
        check("rst_mem_data_out",   mem_data_out,   32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cpu_ready", cpu_ready, 1'b1);

        for (int i = 0; i < NV; i++) begin
            r0 = req_cnt; w0 = wb_cnt;
            cpu_access(vecs[i].wr, vecs[i].addr, vecs[i].wd, 1'b0, rd, lat, rcyc, busy, ok);
            check($sformatf("v%0d_done", i),   ok, 1'b1);
            check($sformatf("v%0d_rdata", i),  rd, vecs[i].exp_rd);
            check($sformatf("v%0d_memreqs", i), req_cnt - r0, vecs[i].exp_req);
            check($sformatf("v%0d_wbs", i),    wb_cnt - w0, vecs[i].exp_wb);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].exp_req > 0) begin
                check($sformatf("v%0d_fill_addr", i),  last_maddr, vecs[i].exp_maddr);
                check($sformatf("v%0d_fill_write", i), mem_write, 1'b0);
            end
            if (vecs[i].exp_wb > 0) begin
                check($sformatf("v%0d_wb_addr", i), last_wbaddr, vecs[i].exp_wbaddr);
                check($sformatf("v%0d_wb_data", i), last_wbdata, vecs[i].exp_wbdata);
            end
        end

        // Long stall: mem_ready low 7 cycles while a second request is held on the CPU side.
        mem_delay = 7;
        r0 = req_cnt;
        cpu_access(1'b0, 32'h100, 8'h00, 1'b1, rd, lat, rcyc, busy, ok);
        check("stall_done",        ok, 1'b1);
        check("stall_rdata",       rd, 8'h44);
        check("stall_memreqs",     req_cnt - r0, 1);
        check("stall_resp_timing", rcyc - rise_cyc, 1);
        check("stall_busy_ready",  busy, 0);
        mem_delay = 3;
        r0 = req_cnt;
        cpu_access(1'b0, 32'h200, 8'h00, 1'b0, rd, lat, rcyc, busy, ok);
        check("held_store_rdata",   rd, 8'h80);
        check("held_store_memreqs", req_cnt - r0, 1);

        // Reset while the fill for 0x300 sits in FILL_LO.
        mem_delay = 5;
        @(negedge clk);
        check("rst2_ready_before", cpu_ready, 1'b1);
        cpu_req_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h300;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst2_fill_issued", seen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_cpu_ready",     cpu_ready,      1'b0);
        check("rst2_mem_req_valid", mem_req_valid,  1'b0);
        check("rst2_resp_valid",    cpu_resp_valid, 1'b0);
        rst = 1'b0;
        c0 = resp_cnt; q0 = req_cnt;
        repeat (10) @(negedge clk);
        check("rst2_no_late_resp", resp_cnt - c0, 0);
        check("rst2_no_new_req",   req_cnt - q0, 0);
        check("rst2_idle_ready",   cpu_ready, 1'b1);
        mem_delay = 3;
        r0 = req_cnt; w0 = wb_cnt;
        cpu_access(1'b0, 32'h3F, 8'h00, 1'b0, rd, lat, rcyc, busy, ok);
        check("rst2_reload_rdata",   rd, 8'h5C);
        check("rst2_reload_memreqs", req_cnt - r0, 1);
        check("rst2_reload_wbs",     wb_cnt - w0, 0);
        r0 = req_cnt;
        cpu_access(1'b0, 32'h200, 8'h00, 1'b0, rd, lat, rcyc, busy, ok);
        check("rst2_line0_rdata",   rd, 8'h80);
        check("rst2_line0_memreqs", req_cnt - r0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller for the cache-coherence lab.
- Sits directly upstream of the block memory model. Its memory side drives the request/ready block protocol that the memory model consumes.
- Its CPU side accepts single-byte load/store requests, one at a time.
- Misses cause a writeback of the dirty victim, if any, then a block fill, then a replay of the lookup.

Parameters:
- BLOCK_BYTES, 4: bytes per block. Power of two. Equals the codebase `BLOCK_SIZE.
- NUM_LINES, 16: cache lines. Power of two.
- ADDR_W, 32: CPU byte-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_req_valid  in  1  CPU request.
- cpu_write  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  8  store byte.
- cpu_ready  out  1  controller can accept a request.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  load result, or stored byte for stores.
- mem_req_valid  out  1  one-cycle memory request pulse.
- mem_write  out  1  1 = writeback, 0 = fill.
- mem_addr  out  ADDR_W-log2(BLOCK_BYTES)  block address.
- mem_data_out  out  BLOCK_BYTES*8  writeback block. Byte i at bits [8i+7:8i].
- mem_ready  in  1  memory idle / transfer done.
- mem_data_in  in  BLOCK_BYTES*8  fill block, valid when mem_ready rises.

Behaviour:
- Reset is synchronous and active-high on clk; clk is the only clock.
- Reset values:
  - cpu_ready=0, cpu_resp_valid=0, cpu_rdata=0.
  - mem_req_valid=0, mem_write=0, mem_addr=0, mem_data_out=0.
  - All valid and dirty bits cleared; state=IDLE.
  - cpu_ready=1 from the first cycle after rst deasserts.
- Address split, taken from cpu_addr:
  - offset = low log2(BLOCK_BYTES) bits.
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- Request acceptance:
  - A request is accepted on the edge where cpu_req_valid && cpu_ready.
  - addr, write and wdata are registered at that edge.
  - cpu_ready is high only in IDLE.
  - A request presented while cpu_ready=0 is not accepted; the CPU holds it.
- FSM states: IDLE, LOOKUP, WB_REQ, WB_LO, WB_HI, FILL_REQ, FILL_LO, FILL_HI.
- IDLE: on accept -> LOOKUP.
- LOOKUP, hit (valid && tag match):
  - Load: cpu_rdata=data[offset].
  - Store: write byte at offset, set dirty, cpu_rdata=wdata.
  - Pulse cpu_resp_valid for one cycle -> IDLE.
  - Hit latency: response in the cycle after acceptance. Next accept possible one cycle after the response.
- LOOKUP, miss:
  - valid && dirty -> WB_REQ.
  - Otherwise -> FILL_REQ. A clean or invalid victim is never written back.
- WB_REQ: only entered/issued when mem_ready=1; holds while mem_ready=0.
  - Drives mem_req_valid=1 for exactly one cycle, with mem_write=1, mem_addr={victim tag, index}, mem_data_out=victim block.
  - -> WB_LO.
- WB_LO: wait for mem_ready=0 -> WB_HI.
- WB_HI: wait for mem_ready=1; clear dirty -> FILL_REQ.
- FILL_REQ: same issue rule as WB_REQ, with mem_write=0 and mem_addr=requested block address -> FILL_LO.
- FILL_LO: wait for mem_ready=0 -> FILL_HI.
- FILL_HI: on mem_ready=1:
  - Capture mem_data_in into the line; set tag, valid=1, dirty=0.
  - -> LOOKUP. The replay then hits, so stores merge after the fill.
- mem_req_valid is 0 in every cycle except the REQ issue cycle. mem_write, mem_addr and mem_data_out hold their value until the next request.
- At most one memory transaction is outstanding. mem_ready is ignored in IDLE/LOOKUP.
- Aliasing: addresses with the same index but different tag evict each other. Index wrap at NUM_LINES-1 -> 0 is purely by bit slicing.
- rst asserted in any state: return to IDLE next edge and invalidate all lines.
  - Any in-flight memory transaction is abandoned.
  - Subsequent mem_ready transitions are ignored until a new request is issued.
- Tags are compared on the full tag width; no partial matching.

Test Plan:
- Reset, then load 0x100 (memory model returns block 0x11223344, byte 0 = 0x44; fixed 3-cycle delay) -> one fill with mem_addr=0x40, mem_write=0; cpu_resp_valid with cpu_rdata=0x44. A repeat load of 0x100 hits with response 1 cycle after accept and no memory request.
- Store 0xAA to 0x101 after that fill -> hit, no memory request, dirty set. Load 0x101 -> 0xAA.
- Load 0x140 (same index 0, new tag) with the line dirty -> writeback (mem_write=1, mem_addr=0x40, mem_data_out byte1=0xAA), then fill mem_addr=0x50, then response. Exactly two mem_req_valid pulses.
- Load 0x140 then 0x100 with clean lines -> fill only, no writeback pulse.
- Memory holds mem_ready low for 7 cycles during a fill -> cpu_ready stays 0, no extra mem_req_valid, response arrives 1 cycle after mem_ready returns. A CPU request presented meanwhile is not accepted.
- Assert rst during FILL_LO -> cpu_ready=0, mem_req_valid=0 at reset. Afterwards the previously filled address misses (line invalidated) and the late mem_ready rise causes no response.
